lif_neuron_mc: RTL and testbench

Multi-input leaky integrate-and-fire neuron: the parametrised successor to the single-input LIF cell. It sums N_IN signed weighted synaptic spikes per cycle, with excitatory and inhibitory weights. It supports shift-based or constant leak, clamps the membrane with saturating arithmetic and enforces a programmable refractory period after each output spike. It sits between the synapse/crossbar stage and the spike router, one instance per neuron in a layer.

---
 rtl/neuron_pkg.sv | 28 ++
 rtl/lif_neuron_mc_syn_accum.sv | 22 ++
 rtl/lif_neuron_mc.sv | 127 ++++++++++++
 tb/tb_lif_neuron_mc.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/neuron_pkg.sv
// Shared types, constants and helpers for the neuron cells.
package neuron_pkg;

  // Neuron FSM: accumulating input, or blanked after an output spike.
  typedef enum logic {
    INTEGRATE  = 1'b0,
    REFRACTORY = 1'b1
  } lif_state_e;

  // Resting membrane potential; also the value every register resets to.
  localparam int RESET_VAL = 0;

  // Saturating clamp of a signed value into [0, 2^(width-1)-1].
  // Callers sign-extend into the 64-bit argument and truncate the result.
  function automatic logic signed [63:0] satClamp(input logic signed [63:0] value,
                                                  input int unsigned width);
    logic signed [63:0] maxVal;
    maxVal = (64'sd1 <<< (width - 1)) - 64'sd1;
    if (value < 64'sd0) begin
      satClamp = 64'sd0;
    end else if (value > maxVal) begin
      satClamp = maxVal;
    end else begin
      satClamp = value;
    end
  endfunction

endpackage

// File: rtl/lif_neuron_mc_syn_accum.sv
// Combinational weighted sum of the synaptic inputs that spiked this cycle.
module syn_accum #(
  parameter int N_IN  = 4,
  parameter int W_WT  = 8,
  parameter int W_SUM = 20
) (
  input  logic [N_IN-1:0]            in_spike_i,
  input  logic [N_IN-1:0][W_WT-1:0]  weight_i,
  output logic signed [W_SUM-1:0]    syn_sum_o
);

  // Sign-extend each active weight and add; W_SUM leaves headroom so it never wraps.
  always_comb begin
    syn_sum_o = '0;
    for (int i = 0; i < N_IN; i++) begin
      if (in_spike_i[i]) begin
        syn_sum_o = syn_sum_o + {{(W_SUM-W_WT){weight_i[i][W_WT-1]}}, weight_i[i]};
      end
    end
  end

endmodule

// File: rtl/lif_neuron_mc.sv
// Multi-input leaky integrate-and-fire neuron with saturating membrane,
// shift or constant leak and a programmable refractory period.
module lif_neuron_mc
  import neuron_pkg::*;
#(
  parameter int N_IN  = 4,
  parameter int W_MEM = 16,
  parameter int W_WT  = 8,
  parameter int W_REF = 4,
  parameter int W_CNT = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic [N_IN-1:0]           in_spike,
  input  logic [N_IN-1:0][W_WT-1:0] weight,
  input  logic                      leak_mode,
  input  logic [3:0]                leak_shift,
  input  logic [W_MEM-1:0]          leak_const,
  input  logic [W_MEM-1:0]          threshold,
  input  logic [W_REF-1:0]          refrac_len,
  output logic                      out_spike,
  output logic [W_MEM-1:0]          potential,
  output logic                      refractory,
  output logic [W_CNT-1:0]          spike_count
);

  localparam int W_EXT = W_MEM + $clog2(N_IN) + 2;

  lif_state_e              state_q, state_d;
  logic [W_MEM-1:0]        potential_q, potential_d;
  logic [W_REF-1:0]        refCnt_q, refCnt_d;
  logic                    outSpike_q, outSpike_d;
  logic [W_CNT-1:0]        spikeCnt_q, spikeCnt_d;

  logic signed [W_EXT-1:0] synSum;
  logic signed [W_EXT-1:0] potExt;
  logic signed [W_EXT-1:0] leakAmt;
  logic signed [W_EXT-1:0] constExt;
  logic signed [W_EXT-1:0] nextExt;
  logic [W_MEM-1:0]        nextPot;
  logic                    fire;

  syn_accum #(
    .N_IN (N_IN),
    .W_WT (W_WT),
    .W_SUM(W_EXT)
  ) u_syn_accum (
    .in_spike_i(in_spike),
    .weight_i  (weight),
    .syn_sum_o (synSum)
  );

  // Leak amount, candidate potential after clamping, and the fire decision.
  always_comb begin
    potExt   = W_EXT'(signed'(potential_q));
    constExt = W_EXT'(leak_const);
    leakAmt  = '0;
    if (leak_mode) begin
      leakAmt = (constExt < potExt) ? constExt : potExt;
    end else if (int'(leak_shift) < W_MEM) begin
      leakAmt = potExt >>> leak_shift;
    end
    nextExt = potExt + synSum - leakAmt;
    nextPot = W_MEM'(satClamp(64'(nextExt), W_MEM));
    fire    = (nextPot >= threshold);
  end

  // Next-state logic: integrate and fire, or count down the refractory period.
  always_comb begin
    state_d     = state_q;
    potential_d = potential_q;
    refCnt_d    = refCnt_q;
    outSpike_d  = 1'b0;
    spikeCnt_d  = spikeCnt_q;
    if (en) begin
      case (state_q)
        INTEGRATE: begin
          if (fire) begin
            outSpike_d  = 1'b1;
            potential_d = W_MEM'(RESET_VAL);
            spikeCnt_d  = (spikeCnt_q == '1) ? spikeCnt_q : spikeCnt_q + W_CNT'(1);
            if (refrac_len != '0) begin
              refCnt_d = refrac_len;
              state_d  = REFRACTORY;
            end
          end else begin
            potential_d = nextPot;
          end
        end
        REFRACTORY: begin
          potential_d = W_MEM'(RESET_VAL);
          if (refCnt_q <= W_REF'(1)) begin
            refCnt_d = '0;
            state_d  = INTEGRATE;
          end else begin
            refCnt_d = refCnt_q - W_REF'(1);
          end
        end
        default: state_d = INTEGRATE;
      endcase
    end
  end

  // State registers; reset wins over enable.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= INTEGRATE;
      potential_q <= W_MEM'(RESET_VAL);
      refCnt_q    <= '0;
      outSpike_q  <= 1'b0;
      spikeCnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      potential_q <= potential_d;
      refCnt_q    <= refCnt_d;
      outSpike_q  <= outSpike_d;
      spikeCnt_q  <= spikeCnt_d;
    end
  end

  assign out_spike   = outSpike_q;
  assign potential   = potential_q;
  assign refractory  = (state_q == REFRACTORY);
  assign spike_count = spikeCnt_q;

endmodule

// File: tb/tb_lif_neuron_mc.sv
// Vector-table bench for lif_neuron_mc with a one-deep expected-output queue.
module tb_lif_neuron_mc;

  logic        clk;
  logic        rst;
  logic        en;
  logic [3:0]  inSpike;
  logic [31:0] weight;
  logic        leakMode;
  logic [3:0]  leakShift;
  logic [15:0] leakConst;
  logic [15:0] threshold;
  logic [3:0]  refracLen;
  logic        outSpike;
  logic [15:0] potential;
  logic        refractory;
  logic [15:0] spikeCount;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       name;
    logic        rst;
    logic        en;
    logic [3:0]  spk;
    logic [31:0] wt;
    logic [15:0] thr;
    logic [3:0]  rlen;
    logic        lmode;
    logic [3:0]  lshift;
    logic [15:0] lconst;
    logic [15:0] ePot;
    logic        eSpk;
    logic        eRef;
    logic [15:0] eCnt;
  } vec_t;

  vec_t vecs[$];
  vec_t sbQ[$];

  logic [15:0] cThr;
  logic [3:0]  cRlen;
  logic        cLmode;
  logic [3:0]  cLshift;
  logic [15:0] cLconst;

  lif_neuron_mc dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .in_spike   (inSpike),
    .weight     (weight),
    .leak_mode  (leakMode),
    .leak_shift (leakShift),
    .leak_const (leakConst),
    .threshold  (threshold),
    .refrac_len (refracLen),
    .out_spike  (outSpike),
    .potential  (potential),
    .refractory (refractory),
    .spike_count(spikeCount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void addVec(input string name, input logic r, input logic e,
                                 input logic [3:0] s, input logic [31:0] w,
                                 input int p, input logic sp, input logic rf, input int c);
    vec_t v;
    v.name = name; v.rst = r; v.en = e; v.spk = s; v.wt = w;
    v.thr = cThr; v.rlen = cRlen; v.lmode = cLmode; v.lshift = cLshift; v.lconst = cLconst;
    v.ePot = 16'(p); v.eSpk = sp; v.eRef = rf; v.eCnt = 16'(c);
    vecs.push_back(v);
  endfunction

  task automatic compare(input string name, input string field, input logic [15:0] got,
                         input logic [15:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("[TB] FAIL %s.%s got %0h expected %0h", name, field, got, want);
    end
  endtask

  task automatic checkOutput();
    vec_t e;
    e = sbQ.pop_front();
    compare(e.name, "potential", potential, e.ePot);
    compare(e.name, "out_spike", 16'(outSpike), 16'(e.eSpk));
    compare(e.name, "refractory", 16'(refractory), 16'(e.eRef));
    compare(e.name, "spike_count", spikeCount, e.eCnt);
  endtask

  task automatic applyStimulus(input vec_t v);
    @(negedge clk);
    rst = v.rst; en = v.en; inSpike = v.spk; weight = v.wt;
    threshold = v.thr; refracLen = v.rlen; leakMode = v.lmode;
    leakShift = v.lshift; leakConst = v.lconst;
    sbQ.push_back(v);
    @(posedge clk);
    #1;
    checkOutput();
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; inSpike = '0; weight = '0; threshold = '0;
    refracLen = '0; leakMode = 1'b0; leakShift = '0; leakConst = '0;

    cThr = 16'd100; cRlen = 4'd0; cLmode = 1'b1; cLshift = 4'd0; cLconst = 16'd0;
    addVec("reset", 1, 1, 4'h0, 32'h0, 0, 0, 0, 0);

    for (int i = 1; i <= 9; i++) addVec("ramp", 0, 1, 4'h1, 32'h0A0A0A0A, 10 * i, 0, 0, 0);
    addVec("rampFire", 0, 1, 4'h1, 32'h0A0A0A0A, 0, 1, 0, 1);

    cRlen = 4'd3;
    addVec("refFire1", 0, 1, 4'hF, 32'h28282828, 0, 1, 1, 2);
    addVec("refHold1", 0, 1, 4'hF, 32'h28282828, 0, 0, 1, 2);
    addVec("refHold2", 0, 1, 4'hF, 32'h28282828, 0, 0, 1, 2);
    addVec("refExit", 0, 1, 4'hF, 32'h28282828, 0, 0, 0, 2);
    addVec("refFire2", 0, 1, 4'hF, 32'h28282828, 0, 1, 1, 3);
    cRlen = 4'd0;
    addVec("noReload1", 0, 1, 4'h0, 32'h0, 0, 0, 1, 3);
    addVec("noReload2", 0, 1, 4'h0, 32'h0, 0, 0, 1, 3);
    addVec("noReload3", 0, 1, 4'h0, 32'h0, 0, 0, 0, 3);

    addVec("to50", 0, 1, 4'h1, 32'h00000032, 50, 0, 0, 3);
    addVec("inhibFloor", 0, 1, 4'h1, 32'h00000080, 0, 0, 0, 3);
    cThr = 16'h7FFF;
    for (int i = 1; i <= 64; i++) addVec("satRamp", 0, 1, 4'hF, 32'h7F7F7F7F, 508 * i, 0, 0, 3);
    addVec("satFire", 0, 1, 4'hF, 32'h7F7F7F7F, 0, 1, 0, 4);

    cLmode = 1'b0; cLshift = 4'd15;
    addVec("to64", 0, 1, 4'h1, 32'h00000040, 64, 0, 0, 4);
    addVec("shift15a", 0, 1, 4'h0, 32'h0, 64, 0, 0, 4);
    addVec("shift15b", 0, 1, 4'h0, 32'h0, 64, 0, 0, 4);
    cLshift = 4'd1;
    for (int i = 5; i >= 0; i--) addVec("shift1", 0, 1, 4'h0, 32'h0, 1 << i, 0, 0, 4);
    cLmode = 1'b1; cLconst = 16'd5;
    addVec("constMin", 0, 1, 4'h0, 32'h0, 0, 0, 0, 4);
    addVec("constRest", 0, 1, 4'h0, 32'h0, 0, 0, 0, 4);

    cLconst = 16'd0; cThr = 16'd10; cRlen = 4'd5;
    addVec("enFire", 0, 1, 4'h1, 32'h00000014, 0, 1, 1, 5);
    for (int i = 0; i < 5; i++) addVec("enFrozen", 0, 0, 4'h1, 32'h00000014, 0, 0, 1, 5);
    for (int i = 0; i < 4; i++) addVec("enResume", 0, 1, 4'h1, 32'h00000014, 0, 0, 1, 5);
    addVec("enExit", 0, 1, 4'h1, 32'h00000014, 0, 0, 0, 5);
    cRlen = 4'd0;
    addVec("zeroRefFire", 0, 1, 4'h1, 32'h00000014, 0, 1, 0, 6);
    cRlen = 4'd4;
    addVec("fire7", 0, 1, 4'h1, 32'h00000014, 0, 1, 1, 7);
    addVec("ref7", 0, 1, 4'h1, 32'h00000014, 0, 0, 1, 7);
    addVec("rstMidRef", 1, 1, 4'h1, 32'h00000014, 0, 0, 0, 0);
    addVec("postRst", 0, 1, 4'h0, 32'h0, 0, 0, 0, 0);
    addVec("postRstFire", 0, 1, 4'h1, 32'h00000014, 0, 1, 1, 1);
    addVec("rstOverEn", 1, 0, 4'h1, 32'h00000014, 0, 0, 0, 0);
    cThr = 16'd100; cRlen = 4'd0;
    addVec("intAcc", 0, 1, 4'h1, 32'h00000014, 20, 0, 0, 0);
    addVec("intFrozen1", 0, 0, 4'h1, 32'h00000014, 20, 0, 0, 0);
    addVec("intFrozen2", 0, 0, 4'h1, 32'h00000014, 20, 0, 0, 0);
    addVec("intResume", 0, 1, 4'h1, 32'h00000014, 40, 0, 0, 0);
    addVec("rstAgain", 1, 1, 4'h0, 32'h0, 0, 0, 0, 0);

    for (int i = 0; i < vecs.size(); i++) applyStimulus(vecs[i]);

    // Threshold 0 fires every enabled cycle; drive the counter into saturation.
    @(negedge clk);
    rst = 1'b0; en = 1'b1; inSpike = '0; threshold = '0; refracLen = '0;
    repeat (65534) @(posedge clk);
    #1;
    compare("cnt65534", "spike_count", spikeCount, 16'hFFFE);
    compare("cnt65534", "out_spike", 16'(outSpike), 16'h1);
    repeat (6) @(posedge clk);
    #1;
    compare("cntSat", "spike_count", spikeCount, 16'hFFFF);
    compare("cntSat", "out_spike", 16'(outSpike), 16'h1);
    compare("cntSat", "potential", potential, 16'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
